imem_loader: RTL and testbench

Program loader that fills the processor's writable instruction memory from a byte stream before execution begins. It accepts bytes over a valid/ready handshake, packs each pair into a 16-bit instruction (first byte is bits 15:8), and writes the words to consecutive instruction-memory addresses starting at 0. It sits between the host/debug byte source and the instruction RAM write port. It holds the core halted until the load completes.

---
 rtl/imem_loader.sv | 89 ++++++++
 tb/tb_imem_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Program loader: packs a valid/ready byte stream into 16-bit instructions and
// writes them to instruction RAM from address 0, holding the core until done.
module imem_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  cpu_run
);

  typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] MaxWords = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] OneWord  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q;
  logic [ADDR_WIDTH:0]   addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic [7:0]            hi_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [ADDR_WIDTH:0]   count_clamped_d;
  logic                  xfer;

  // word_count carries one extra bit, so any value with it set is at least the RAM depth
  assign count_clamped_d = word_count[ADDR_WIDTH] ? MaxWords : word_count;
  assign xfer            = byte_valid && byte_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      hi_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            remaining_q <= count_clamped_d;
            addr_q      <= '0;
            state_q     <= (count_clamped_d == '0) ? DONE : HI;
          end
        end
        HI: begin
          if (xfer) begin
            hi_q    <= byte_data;
            state_q <= LO;
          end
        end
        LO: begin
          if (xfer) begin
            mem_wdata_q <= {hi_q, byte_data};
            mem_addr_q  <= addr_q[ADDR_WIDTH-1:0];
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          // addr_q is one bit wider than the RAM address, so stepping past the last word cannot wrap
          addr_q      <= addr_q + OneWord;
          remaining_q <= remaining_q - OneWord;
          state_q     <= (remaining_q == OneWord) ? DONE : HI;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_ready = (state_q == HI) || (state_q == LO);
  assign mem_we     = (state_q == WRITE);
  assign busy       = (state_q == HI) || (state_q == LO) || (state_q == WRITE);
  assign done       = (state_q == DONE);
  assign cpu_run    = (state_q == DONE);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed and randomized load sessions checked
// against an expected write list derived from the byte stream and word count.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  word_count;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        cpu_run;

  int checks;
  int errors;
  logic [7:0] bytesQ[$];

  imem_loader #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .cpu_run    (cpu_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".byte_ready"}, byte_ready, 0);
    checkOutput({tag, ".mem_we"}, mem_we, 0);
    checkOutput({tag, ".mem_addr"}, mem_addr, 0);
    checkOutput({tag, ".mem_wdata"}, mem_wdata, 0);
    checkOutput({tag, ".busy"}, busy, 0);
    checkOutput({tag, ".done"}, done, 0);
    checkOutput({tag, ".cpu_run"}, cpu_run, 0);
  endtask

  task automatic fillRandom(input int n);
    bytesQ.delete();
    for (int i = 0; i < n; i++) bytesQ.push_back(8'($urandom));
  endtask

  // One load session: start with count, offer bytesQ with the given valid
  // probability (-1 = repeating 1,0,0,1 pattern), optionally reset after
  // abortAfter accepted bytes. Expected writes: word i = {byte 2i, byte 2i+1}
  // at address i for i < min(count, 32).
  task automatic applyStimulus(input int count, input int validPct, input int abortAfter);
    int  eff, idx, strobes, lastStrobe, doneCyc, cyc;
    bit  finished, readySeen, aborted, v;
    eff = (count > 32) ? 32 : count;
    idx = 0; strobes = 0; lastStrobe = -1; doneCyc = -1;
    finished = 0; readySeen = 0; aborted = 0;
    @(negedge clk);
    start      = 1'b1;
    word_count = 6'(count);
    byte_valid = 1'b1;
    byte_data  = 8'($urandom);
    @(negedge clk);
    start = 1'b0;
    checkOutput("busyAfterStart", busy, (eff != 0));
    checkOutput("doneAfterStart", done, (eff == 0));
    for (cyc = 0; cyc < 1000 && !finished && !aborted; cyc++) begin
      if (byte_ready) readySeen = 1;
      if (mem_we) begin
        if (strobes < eff) begin
          checkOutput("writeAddr", mem_addr, strobes);
          checkOutput("writeData", mem_wdata, {bytesQ[2*strobes], bytesQ[2*strobes+1]});
        end else begin
          checkOutput("extraStrobe", strobes, eff);
        end
        checkOutput("readyInWrite", byte_ready, 0);
        strobes++;
        lastStrobe = cyc;
      end
      if (done) begin
        finished = 1;
        doneCyc  = cyc;
        checkOutput("doneTiming", cyc, (eff == 0) ? 0 : lastStrobe + 1);
      end else if (abortAfter >= 0 && idx == abortAfter) begin
        aborted = 1;
      end else begin
        checkOutput("busyInSession", busy, 1);
        if (validPct < 0) v = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        else              v = ($urandom_range(0, 99) < validPct);
        byte_valid = v && (idx < bytesQ.size());
        byte_data  = byte_valid ? bytesQ[idx] : 8'($urandom);
        if (byte_valid && byte_ready) idx++;
        @(negedge clk);
      end
    end

    if (aborted) begin
      rst_n      = 1'b0;
      start      = 1'b1;
      byte_valid = 1'b1;
      @(negedge clk);
      checkAllZero("abortReset");
      checkOutput("abortStrobes", strobes, abortAfter / 2);
      rst_n      = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
    end else begin
      checkOutput("sessionEnded", finished, 1);
      checkOutput("strobeCount", strobes, eff);
      checkOutput("transferCount", idx, 2 * eff);
      if (validPct == 100) checkOutput("throughput", doneCyc, 3 * eff);
      if (eff == 0) checkOutput("zeroNoReady", readySeen, 0);
      checkOutput("doneCpuRun", cpu_run, 1);
      checkOutput("doneBusy", busy, 0);
      checkOutput("doneReady", byte_ready, 0);
      byte_valid = 1'b1;
      repeat (3) begin
        @(negedge clk);
        checkOutput("holdDone", done, 1);
        checkOutput("holdNoWrite", mem_we, 0);
        checkOutput("holdNoReady", byte_ready, 0);
      end
      byte_valid = 1'b0;
    end
  endtask

  initial begin
    int cnt, eff;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    start      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    word_count = 6'd5;
    repeat (2) begin
      @(negedge clk);
      checkAllZero("reset");
    end
    rst_n      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    checkAllZero("idleAfterReset");

    $display("[TB] basic load");
    bytesQ = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    applyStimulus(2, 100, -1);

    $display("[TB] backpressure");
    fillRandom(2);
    applyStimulus(1, -1, -1);

    $display("[TB] clamp");
    fillRandom(80);
    applyStimulus(40, 100, -1);

    $display("[TB] zero count");
    fillRandom(4);
    applyStimulus(0, 100, -1);

    $display("[TB] abort and restart");
    fillRandom(8);
    applyStimulus(4, 100, 3);
    bytesQ = '{8'hDE, 8'hAD};
    applyStimulus(1, 100, -1);

    $display("[TB] random sessions");
    for (int s = 0; s < 6; s++) begin
      cnt = $urandom_range(0, 63);
      eff = (cnt > 32) ? 32 : cnt;
      fillRandom(2 * eff + $urandom_range(0, 4));
      applyStimulus(cnt, $urandom_range(30, 100), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
